// File: rtl/aes256_round_key_streamer_if.sv
// Key-load and round-key stream bundle for aes256_round_key_streamer.
// Optional feature macro: KEYSCHED_REVERSE_EN adds the dir_rev signal.
interface aes256_round_key_streamer_if;
    logic [255:0] key_in;
    logic         key_load;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_data;
    logic [3:0]   rk_index;
    logic         done;
`ifdef KEYSCHED_REVERSE_EN
    logic         dir_rev;
`endif

    // Key-schedule side: consumes the key, produces the round-key stream.
    modport master (
        input  key_in, key_load, rk_ready,
`ifdef KEYSCHED_REVERSE_EN
        input  dir_rev,
`endif
        output busy, rk_valid, rk_data, rk_index, done
    );

    // Host/consumer side.
    modport slave (
        output key_in, key_load, rk_ready,
`ifdef KEYSCHED_REVERSE_EN
        output dir_rev,
`endif
        input  busy, rk_valid, rk_data, rk_index, done
    );
endinterface

// File: rtl/aes256_round_key_streamer.sv
// Sequential AES-256 key schedule streaming 15 round keys over valid/ready.
// A 256-bit window holds one round-key pair; one pair step (two SubWord
// instances) advances it after the odd key of the pair is accepted.
// Optional feature macro: KEYSCHED_REVERSE_EN (buffered reverse-order stream).
module aes256_round_key_streamer #(
    parameter int unsigned NUM_RK = 15,  // must be 15 for AES-256
    parameter int unsigned RK_W   = 128
) (
    input  logic                               clk,
    input  logic                               rst_n,
    aes256_round_key_streamer_if.master        bus
);

    localparam logic [3:0] LastIdx = 4'(NUM_RK - 1);

    typedef enum logic [1:0] {StIdle, StEmit, StFill, StRemit} state_e;

    state_e              state_q, state_d;
    logic [2*RK_W-1:0]   win_q;
    logic [3:0]          idx_q;
    logic                done_q;
    logic                valid_c;
    logic                hs_c;
    logic                rev_c;
    logic [2:0]          step_j_c;
    logic [2*RK_W-1:0]   step_c;

`ifdef KEYSCHED_REVERSE_EN
    logic [RK_W-1:0]     kbuf_q [NUM_RK];
    assign rev_c = bus.dir_rev;
`else
    assign rev_c = 1'b0;
`endif

    // GF(2^8) multiply, AES polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box as inverse (a^254, so 0 maps to 0) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            inv = gf_mul(inv, inv);
            if (i != 0) inv = gf_mul(inv, a);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Advance {rk[2j-2], rk[2j-1]} to {rk[2j], rk[2j+1]}.
    function automatic logic [255:0] pair_step(input logic [255:0] o_win, input logic [2:0] j);
        logic [31:0] o [8];
        logic [31:0] n [8];
        logic [7:0]  rcon;
        for (int k = 0; k < 8; k++) o[k] = o_win[255 - 32*k -: 32];
        rcon = 8'h01 << (j - 3'd1);
        n[0] = sub_word({o[7][23:0], o[7][31:24]}) ^ {rcon, 24'h0} ^ o[0];
        n[1] = o[1] ^ n[0];
        n[2] = o[2] ^ n[1];
        n[3] = o[3] ^ n[2];
        n[4] = sub_word(n[3]) ^ o[4];
        n[5] = o[5] ^ n[4];
        n[6] = o[6] ^ n[5];
        n[7] = o[7] ^ n[6];
        return {n[0], n[1], n[2], n[3], n[4], n[5], n[6], n[7]};
    endfunction

    assign hs_c = valid_c & bus.rk_ready;

    // Step index: (i+1)/2 after odd key i while emitting, counter while filling.
    always_comb begin
        step_j_c = (state_q == StFill) ? idx_q[2:0] : idx_q[3:1] + 3'd1;
        step_c   = pair_step(win_q, step_j_c);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Next-state logic; loads are only honoured in idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (bus.key_load) state_d = rev_c ? StFill : StEmit;
            StEmit:  if (hs_c && idx_q == LastIdx) state_d = StIdle;
`ifdef KEYSCHED_REVERSE_EN
            StFill:  if (idx_q == 4'd7) state_d = StRemit;
            StRemit: if (hs_c && idx_q == 4'd0) state_d = StIdle;
`endif
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from state, window and buffer.
    always_comb begin
        valid_c      = 1'b0;
        bus.rk_data  = '0;
        case (state_q)
            StEmit: begin
                valid_c     = 1'b1;
                bus.rk_data = idx_q[0] ? win_q[RK_W-1:0] : win_q[2*RK_W-1:RK_W];
            end
`ifdef KEYSCHED_REVERSE_EN
            StRemit: begin
                valid_c     = 1'b1;
                bus.rk_data = kbuf_q[idx_q];
            end
`endif
            default: ;
        endcase
        bus.rk_valid = valid_c;
        bus.busy     = (state_q != StIdle);
        bus.rk_index = idx_q;
        bus.done     = done_q;
    end

    // Window, index and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q  <= '0;
            idx_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: if (bus.key_load) begin
                    win_q <= bus.key_in;
                    idx_q <= rev_c ? 4'd1 : 4'd0;  // fill reuses idx as step counter
                end
                StEmit: if (hs_c) begin
                    if (idx_q == LastIdx) begin
                        done_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 4'd1;
                        if (idx_q[0]) win_q <= step_c;
                    end
                end
                StFill: begin
                    win_q <= step_c;
                    idx_q <= (idx_q == 4'd7) ? LastIdx : idx_q + 4'd1;
                end
                StRemit: if (hs_c) begin
                    if (idx_q == 4'd0) done_q <= 1'b1;
                    else               idx_q  <= idx_q - 4'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef KEYSCHED_REVERSE_EN
    // Reverse buffer: pair 0 on load, pairs 1..7 during fill (rk15 dropped).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(NUM_RK); k++) kbuf_q[k] <= '0;
        end else if (state_q == StIdle && bus.key_load && rev_c) begin
            kbuf_q[0] <= bus.key_in[2*RK_W-1:RK_W];
            kbuf_q[1] <= bus.key_in[RK_W-1:0];
        end else if (state_q == StFill) begin
            kbuf_q[{idx_q[2:0], 1'b0}] <= step_c[2*RK_W-1:RK_W];
            if (idx_q != 4'd7) kbuf_q[{idx_q[2:0], 1'b1}] <= step_c[RK_W-1:0];
        end
    end
`endif

endmodule

// File: tb/tb_aes256_round_key_streamer.sv
// Directed bench for aes256_round_key_streamer using the FIPS-197 AES-256
// example key 000102..1f. Build with KEYSCHED_REVERSE_EN to cover reverse mode.
module tb_aes256_round_key_streamer;

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] rk;
    } vec_t;

    localparam logic [255:0] KeyA = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   passed = 0;
    vec_t vecs [15];

    always #5 clk = ~clk;

    aes256_round_key_streamer_if bus ();

    aes256_round_key_streamer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    task automatic check_key(input int i);
        check($sformatf("rk%0d valid", i), 128'(bus.rk_valid), 128'd1);
        check($sformatf("rk%0d index", i), 128'(bus.rk_index), 128'(vecs[i].idx));
        check($sformatf("rk%0d data", i), bus.rk_data, vecs[i].rk);
    endtask

    task automatic check_idle(input string name, input logic exp_done);
        check({name, " valid"}, 128'(bus.rk_valid), 128'd0);
        check({name, " busy"}, 128'(bus.busy), 128'd0);
        check({name, " done"}, 128'(bus.done), 128'(exp_done));
    endtask

    // Called at a negedge while idle; returns at the next negedge (first key visible).
    task automatic start_load(input logic [255:0] key, input logic rev);
        bus.key_in   = key;
        bus.key_load = 1'b1;
`ifdef KEYSCHED_REVERSE_EN
        bus.dir_rev  = rev;
`else
        if (rev) $display("reverse load requested without reverse support");
`endif
        @(negedge clk);
        bus.key_load = 1'b0;
`ifdef KEYSCHED_REVERSE_EN
        bus.dir_rev  = 1'b0;
`endif
    endtask

    // Walk the forward stream from rk0 with optional corner-case injections (-1 = off).
    task automatic run_stream(input int hold_at, input int busy_load_at,
                              input int reset_at, input bit load_at_end);
        for (int i = 0; i < 15; i++) begin
            check_key(i);
            if (i == reset_at) begin
                #2 rst_n = 1'b0;
                #1;
                check_idle("async reset", 1'b0);
                check("async reset data", bus.rk_data, 128'd0);
                check("async reset index", 128'(bus.rk_index), 128'd0);
                @(negedge clk);
                rst_n = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    check_idle("post-reset", 1'b0);
                end
                return;
            end
            if (i == hold_at) begin
                bus.rk_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check_key(i);
                end
                bus.rk_ready = 1'b1;
            end
            if (i == busy_load_at) begin
                bus.key_in   = '1;
                bus.key_load = 1'b1;
            end
            if (i == 14 && load_at_end) bus.key_load = 1'b1;
            @(negedge clk);
            bus.key_load = 1'b0;
            bus.key_in   = KeyA;
            if (i == busy_load_at) check("busy during ignored load", 128'(bus.busy), 128'd1);
        end
        check_idle("end", 1'b1);
        @(negedge clk);
        check_idle("after done", 1'b0);
    endtask

    initial begin
        vecs[0]  = '{4'd0,  128'h000102030405060708090a0b0c0d0e0f};
        vecs[1]  = '{4'd1,  128'h101112131415161718191a1b1c1d1e1f};
        vecs[2]  = '{4'd2,  128'ha573c29fa176c498a97fce93a572c09c};
        vecs[3]  = '{4'd3,  128'h1651a8cd0244beda1a5da4c10640bade};
        vecs[4]  = '{4'd4,  128'hae87dff00ff11b68a68ed5fb03fc1567};
        vecs[5]  = '{4'd5,  128'h6de1f1486fa54f9275f8eb5373b8518d};
        vecs[6]  = '{4'd6,  128'hc656827fc9a799176f294cec6cd5598b};
        vecs[7]  = '{4'd7,  128'h3de23a75524775e727bf9eb45407cf39};
        vecs[8]  = '{4'd8,  128'h0bdc905fc27b0948ad5245a4c1871c2f};
        vecs[9]  = '{4'd9,  128'h45f5a66017b2d387300d4d33640a820a};
        vecs[10] = '{4'd10, 128'h7ccff71cbeb4fe5413e6bbf0d261a7df};
        vecs[11] = '{4'd11, 128'hf01afafee7a82979d7a5644ab3afe640};
        vecs[12] = '{4'd12, 128'h2541fe719bf500258813bbd55a721c0a};
        vecs[13] = '{4'd13, 128'h4e5a6699a9f24fe07e572baacdf8cdea};
        vecs[14] = '{4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36};

        bus.key_in   = '0;
        bus.key_load = 1'b0;
        bus.rk_ready = 1'b1;
`ifdef KEYSCHED_REVERSE_EN
        bus.dir_rev  = 1'b0;
`endif

        // Reset state.
        repeat (2) @(negedge clk);
        check_idle("reset", 1'b0);
        check("reset data", bus.rk_data, 128'd0);
        check("reset index", 128'(bus.rk_index), 128'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("idle after release", 1'b0);

        // Forward stream with rk_ready tied high.
        start_load(KeyA, 1'b0);
        check("busy after load", 128'(bus.busy), 128'd1);
        run_stream(-1, -1, -1, 1'b0);

        // Backpressure at index 3, then a load while busy at index 6.
        start_load(KeyA, 1'b0);
        run_stream(3, 6, -1, 1'b0);

        // Async reset mid-stream, then a fresh stream that ends with a
        // load in the final-handshake cycle.
        start_load(KeyA, 1'b0);
        run_stream(-1, -1, 9, 1'b0);
        start_load(KeyA, 1'b0);
        run_stream(-1, -1, -1, 1'b1);

        // Load two cycles after the final handshake: rk0 with latency 1.
        start_load(KeyA, 1'b0);
        check_key(0);
        @(negedge clk);
        check_key(1);

`ifdef KEYSCHED_REVERSE_EN
        // Drain, then reverse order.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_load(KeyA, 1'b1);
        for (int c = 0; c < 7; c++) begin
            check($sformatf("fill cycle %0d valid", c), 128'(bus.rk_valid), 128'd0);
            @(negedge clk);
        end
        for (int i = 14; i >= 0; i--) begin
            check_key(i);
            @(negedge clk);
        end
        check_idle("reverse end", 1'b1);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    // Safety net against a stalled run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", passed, checks);
        $fatal(1);
    end

endmodule

// File: doc/aes256_round_key_streamer.md
Name: aes256_round_key_streamer

Overview:
- Sequential AES-256 key schedule. It sits upstream of the iterative encrypt/decrypt round datapath.
- Accepts one 256-bit cipher key and streams the 15 round keys (128 bits each) over a valid/ready interface, one key per accepted transfer.
- Replaces the fully unrolled combinational schedule with one two-word-group step per round pair. The step is built from 8 S-box lookups: two 32-bit SubBytes instances.

Parameters:
- NUM_RK, 15, number of round keys emitted. Fixed for AES-256; any other value is illegal.
- RK_W, 128, round-key width in bits.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- key_in  in  256  cipher key, word 0 at [255:224]. Sampled only on load acceptance.
- key_load  in  1  start request. Accepted only when busy=0.
- busy  out  1  high from load acceptance until the final handshake completes.
- rk_valid  out  1  rk_data/rk_index are valid.
- rk_ready  in  1  consumer accepts the current key.
- rk_data  out  128  current round key.
- rk_index  out  4  round number of rk_data, range 0..14.
- done  out  1  one-cycle pulse after the last round key is accepted.
- dir_rev  in  1  present only with KEYSCHED_REVERSE_EN. Sampled on load.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, rk_valid=0, rk_data=0, rk_index=0, done=0; window register and key buffer cleared. Assertion mid-stream aborts immediately. No key is emitted after release until a new key_load.
- Internal window win[255:0] holds the pair {rk[2j], rk[2j+1]}.
  - Even index: rk_data=win[255:128].
  - Odd index: rk_data=win[127:0].
- Pair step, j = 1..7, Rcon byte = 8'h01<<(j-1) in the top byte. Words n0..n7 are computed from the old words o0..o7:
  - n0 = SubWord(RotWord(o7)) ^ Rcon ^ o0
  - n1..n3: chained XOR (n1 = o1 ^ n0, etc.)
  - n4 = SubWord(n3) ^ o4 (no rotate, no Rcon)
  - n5..n7: chained XOR
- FSM IDLE:
  - key_load=1 → win=key_in, rk_index=0, busy=1, state=EMIT.
  - rk_valid rises on the cycle after the load edge (latency 1).
- FSM EMIT:
  - rk_valid=1. rk_data and rk_index are held stable while rk_ready=0.
  - Handshake (rk_valid&rk_ready) at odd index i<14 → win updated by the pair step with j=(i+1)/2 on the same edge, and rk_index=i+1. Back-to-back handshakes sustain one key per clock.
  - Handshake at even index i<14 → rk_index=i+1 only.
  - Handshake at index 14 → rk_valid=0, busy=0, done=1 for one cycle, state=IDLE.
- key_load while busy=1 is ignored (no restart, no corruption).
- key_load on the same cycle as the final handshake is ignored. The next load is accepted at the earliest one cycle later, when busy=0.
- rk_index never exceeds 14 and never wraps.

Optional Feature:
- Macro KEYSCHED_REVERSE_EN.
- Defined:
  - Port dir_rev exists, plus an internal 15x128 key buffer.
  - Load with dir_rev=1 → state FILL: rk_index 0..1 and the pair steps j=1..7 are written to the buffer, one pair per cycle (7 cycles), with rk_valid=0.
  - Then state REMIT emits rk_index 14 down to 0 under the same handshake rules. done pulses after index 0 is accepted.
  - Load with dir_rev=0 behaves exactly as forward mode.
- Undefined: no dir_rev port, no buffer, forward order only.

Test Plan:
- Forward stream, key_in=000102..1f, rk_ready=1 tied → 15 consecutive valid cycles:
  - rk0=000102..0f
  - rk1=101112..1f
  - rk2=a573c29fa176c498a97fce93a572c09c
  - rk3=1651a8cd0244beda1a5da4c10640bade
  - rk14=24fc79ccbf0979e9371ac23c6d68de36
  - done pulses once, busy falls with it.
- Backpressure: rk_ready held 0 for 5 cycles at rk_index=3 → rk_data stays 1651a8cd...bade and index stays 3; stream resumes with correct rk4 and the final sequence is unchanged.
- key_load with key 0xff..ff while busy at index 6 → ignored; remaining keys still match the 000102..1f schedule.
- rst_n pulsed low at index 9 → all outputs 0 immediately; after release, rk_valid stays 0 until a new key_load, and the new stream starts at rk_index 0.
- key_load asserted in the cycle of the final handshake → ignored; a load two cycles later yields rk0 with latency 1.
- (KEYSCHED_REVERSE_EN) dir_rev=1, key 000102..1f → rk_valid low for 7 cycles, then first key=24fc79cc...de36 with index 14, last key=000102..0f with index 0, then done.
